// File: rtl/shift_pkg.sv
// Shared definitions for the sequential shift/rotate unit: operation
// encodings, FSM state encoding and a PASS-decode helper.
package shift_pkg;

    // Operation encodings on the 3-bit mode input; 101..111 all mean PASS.
    localparam logic [2:0] SHR  = 3'b000;
    localparam logic [2:0] SHRA = 3'b001;
    localparam logic [2:0] SHL  = 3'b010;
    localparam logic [2:0] ROR  = 3'b011;
    localparam logic [2:0] ROL  = 3'b100;
    localparam logic [2:0] PASS = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Every encoding above ROL behaves as PASS.
    function automatic logic is_pass(input logic [2:0] m);
        return (m >= PASS);
    endfunction

endpackage

// File: rtl/shift_step.sv
// One combinational shift/rotate step of 0..STEP bit positions.
// Ports:
//   i_value    operand for this step
//   i_mode     operation (SHR/SHRA/SHL/ROR/ROL, anything else passes through)
//   i_fill     fill bit for right shifts (0 for SHR, captured sign for SHRA)
//   i_k        step amount, 0..STEP
//   o_value_c  shifted/rotated result (combinational)
module shift_step
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic [WIDTH-1:0]            i_value,
    input  logic [2:0]                  i_mode,
    input  logic                        i_fill,
    input  logic [$clog2(STEP+1)-1:0]   i_k,
    output logic [WIDTH-1:0]            o_value_c
);

    // Double-width scratch: the upper half supplies fill or wrap-around bits.
    logic [2*WIDTH-1:0] w_wide;

    always_comb begin
        w_wide    = '0;
        o_value_c = i_value;
        case (i_mode)
            SHR, SHRA: begin
                w_wide    = {{WIDTH{i_fill}}, i_value} >> i_k;
                o_value_c = w_wide[WIDTH-1:0];
            end
            SHL: begin
                o_value_c = i_value << i_k;
            end
            ROR: begin
                w_wide    = {i_value, i_value} >> i_k;
                o_value_c = w_wide[WIDTH-1:0];
            end
            ROL: begin
                w_wide    = {i_value, i_value} << i_k;
                o_value_c = w_wide[2*WIDTH-1:WIDTH];
            end
            default: begin
                o_value_c = i_value;
            end
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// Multi-cycle shift/rotate unit: consumes up to STEP bit positions per clock
// behind a start/busy/done handshake.
// Ports:
//   clock   rising-edge clock
//   clear   synchronous active-high reset, aborts any operation in flight
//   start   request, only honoured while idle
//   mode    operation select (see shift_pkg)
//   B       operand
//   shifts  shift amount 0..WIDTH-1
//   busy    high whenever not idle (registered)
//   done    one-cycle completion pulse (registered)
//   Result  result register, holds until the next completion or clear
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic                        clock,
    input  logic                        clear,
    input  logic                        start,
    input  logic [2:0]                  mode,
    input  logic [WIDTH-1:0]            B,
    input  logic [$clog2(WIDTH)-1:0]    shifts,
    output logic                        busy,
    output logic                        done,
    output logic [WIDTH-1:0]            Result
);

    localparam int unsigned SW = $clog2(WIDTH);
    localparam int unsigned KW = $clog2(STEP + 1);

    state_e           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_work, w_work_nxt;
    logic [SW-1:0]    r_count, w_count_nxt;
    logic [2:0]       r_mode, w_mode_nxt;
    logic             r_fill, w_fill_nxt;
    logic [WIDTH-1:0] r_result, w_result_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;

    logic [KW-1:0]    w_k;
    logic [SW-1:0]    w_count_left;
    logic [WIDTH-1:0] w_step_val;

    // Step size for this iteration: min(STEP, remaining count).
    always_comb begin
        w_k          = (32'(r_count) >= STEP) ? KW'(STEP) : KW'(r_count);
        w_count_left = r_count - SW'(w_k);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .i_value   (r_work),
        .i_mode    (r_mode),
        .i_fill    (r_fill),
        .i_k       (w_k),
        .o_value_c (w_step_val)
    );

    // Next-state and next-register logic.
    always_comb begin
        w_state_nxt  = r_state;
        w_work_nxt   = r_work;
        w_count_nxt  = r_count;
        w_mode_nxt   = r_mode;
        w_fill_nxt   = r_fill;
        w_result_nxt = r_result;
        w_busy_nxt   = 1'b0;
        w_done_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_work_nxt  = B;
                    w_mode_nxt  = mode;
                    // Sign is frozen at capture; only SHRA fills with it.
                    w_fill_nxt  = (mode == SHRA) & B[WIDTH-1];
                    w_count_nxt = shifts;
                    if ((shifts == '0) || is_pass(mode)) begin
                        w_state_nxt  = ST_DONE;
                        w_result_nxt = B;
                    end else begin
                        w_state_nxt  = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                w_work_nxt  = w_step_val;
                w_count_nxt = w_count_left;
                if (w_count_left == '0) begin
                    w_state_nxt  = ST_DONE;
                    w_result_nxt = w_step_val;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Outputs are registered from the next state, so they track the state.
        w_busy_nxt = (w_state_nxt != ST_IDLE);
        w_done_nxt = (w_state_nxt == ST_DONE);
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_work   <= '0;
            r_count  <= '0;
            r_mode   <= '0;
            r_fill   <= 1'b0;
            r_result <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_work   <= w_work_nxt;
            r_count  <= w_count_nxt;
            r_mode   <= w_mode_nxt;
            r_fill   <= w_fill_nxt;
            r_result <= w_result_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign Result = r_result;

endmodule

// File: tb/tb_seq_shift_unit.sv
// Bench for seq_shift_unit: three instances (STEP 1, 4, 32) share one input
// stream; a latency/arithmetic model is compared every cycle, and directed
// operations pin results and latencies with literal values.
module tb_seq_shift_unit;

    logic        clock;
    logic        clear;
    logic        start;
    logic [2:0]  mode;
    logic [31:0] B;
    logic [4:0]  shifts;

    logic        busy_w [3];
    logic        done_w [3];
    logic [31:0] res_w  [3];

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    seq_shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (
        .clock(clock), .clear(clear), .start(start), .mode(mode), .B(B),
        .shifts(shifts), .busy(busy_w[0]), .done(done_w[0]), .Result(res_w[0]));

    seq_shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (
        .clock(clock), .clear(clear), .start(start), .mode(mode), .B(B),
        .shifts(shifts), .busy(busy_w[1]), .done(done_w[1]), .Result(res_w[1]));

    seq_shift_unit #(.WIDTH(32), .STEP(32)) u_s32 (
        .clock(clock), .clear(clear), .start(start), .mode(mode), .B(B),
        .shifts(shifts), .busy(busy_w[2]), .done(done_w[2]), .Result(res_w[2]));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int step_of(input int i);
        case (i)
            0: return 1;
            1: return 4;
            default: return 32;
        endcase
    endfunction

    function automatic logic [31:0] ref_op(input logic [2:0] md, input logic [31:0] b, input int n);
        case (md)
            3'd0: return b >> n;
            3'd1: return $unsigned($signed(b) >>> n);
            3'd2: return b << n;
            3'd3: return (n == 0) ? b : ((b >> n) | (b << (32 - n)));
            3'd4: return (n == 0) ? b : ((b << n) | (b >> (32 - n)));
            default: return b;
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] md, input int n, input int s);
        if (n == 0 || md >= 3'd5) return 0;
        return (n + s - 1) / s;
    endfunction

    // ph: 0 idle, 1 shifting (cnt edges left), 2 done cycle
    int          m_ph   [3];
    int          m_cnt  [3];
    logic [31:0] m_pend [3];
    logic [31:0] m_res  [3];

    always @(posedge clock) begin
        for (int i = 0; i < 3; i++) begin
            if (clear) begin
                m_ph[i]  = 0;
                m_res[i] = 32'h0;
            end else begin
                case (m_ph[i])
                    0: if (start) begin
                        m_pend[i] = ref_op(mode, B, int'(shifts));
                        m_cnt[i]  = ref_lat(mode, int'(shifts), step_of(i));
                        if (m_cnt[i] == 0) begin
                            m_ph[i]  = 2;
                            m_res[i] = m_pend[i];
                        end else begin
                            m_ph[i] = 1;
                        end
                    end
                    1: begin
                        m_cnt[i]--;
                        if (m_cnt[i] == 0) begin
                            m_ph[i]  = 2;
                            m_res[i] = m_pend[i];
                        end
                    end
                    default: m_ph[i] = 0;
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("model busy[%0d]", i), 32'(busy_w[i]), 32'(m_ph[i] != 0));
                check($sformatf("model done[%0d]", i), 32'(done_w[i]), 32'(m_ph[i] == 2));
                check($sformatf("model result[%0d]", i), res_w[i], m_res[i]);
            end
        end
    end

    // ---------------- directed operations ----------------
    task automatic run_op(input string nm, input logic [2:0] md, input logic [31:0] b,
                          input logic [4:0] n, input logic [31:0] exp_res,
                          input int l0, input int l1, input int l2, input bit pulse);
        int lat [3];
        bit seen [3];
        int busy_cyc;
        bit fin;
        int exp_lat [3];
        exp_lat[0] = l0; exp_lat[1] = l1; exp_lat[2] = l2;
        for (int i = 0; i < 3; i++) begin
            lat[i]  = -1;
            seen[i] = 1'b0;
        end
        busy_cyc = 0;
        fin      = 1'b0;
        @(negedge clock);
        mode = md; B = b; shifts = n; start = 1'b1;
        for (int c = 0; c < 80; c++) begin
            @(negedge clock);   // cycle after edge E(c)
            for (int i = 0; i < 3; i++) begin
                if (done_w[i] && !seen[i]) begin
                    seen[i] = 1'b1;
                    lat[i]  = c;
                end
            end
            if (busy_w[0]) busy_cyc++;
            if (pulse && c < 2) begin
                start = 1'b1; B = 32'hFFFF_FFFF; mode = 3'd3; shifts = 5'd3;
            end else begin
                start = 1'b0;
            end
            fin = seen[0] && seen[1] && seen[2] && !busy_w[0] && !busy_w[1] && !busy_w[2];
            if (fin) break;
        end
        check({nm, " finished"}, 32'(fin), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s result[%0d]", nm, i), res_w[i], exp_res);
            check($sformatf("%s latency[%0d]", nm, i), 32'(lat[i]), 32'(exp_lat[i]));
        end
        check({nm, " busy cycles"}, 32'(busy_cyc), 32'(l0 + 1));
    endtask

    initial begin
        bit saw_done;
        clear = 1'b1; start = 1'b0; mode = 3'd0; B = 32'h0; shifts = 5'd0;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("reset busy[%0d]", i), 32'(busy_w[i]), 32'd0);
            check($sformatf("reset done[%0d]", i), 32'(done_w[i]), 32'd0);
            check($sformatf("reset result[%0d]", i), res_w[i], 32'h0);
        end
        clear = 1'b0;

        run_op("shr4",   3'd0, 32'hA5A5_A5A5, 5'd4,  32'h0A5A_5A5A, 4, 1, 1, 1'b0);
        run_op("shra31", 3'd1, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 31, 8, 1, 1'b0);
        run_op("shl16",  3'd2, 32'h1234_5678, 5'd16, 32'h5678_0000, 16, 4, 1, 1'b0);
        run_op("ror8",   3'd3, 32'hDEAD_BEEF, 5'd8,  32'hEFDE_ADBE, 8, 2, 1, 1'b0);
        run_op("rol1",   3'd4, 32'h8000_0001, 5'd1,  32'h0000_0003, 1, 1, 1, 1'b0);
        run_op("zero",   3'd0, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFF, 0, 0, 0, 1'b0);
        run_op("pass9",  3'd5, 32'hCAFE_F00D, 5'd9,  32'hCAFE_F00D, 0, 0, 0, 1'b0);
        run_op("busy_start", 3'd2, 32'h0000_ABCD, 5'd12, 32'h0ABC_D000, 12, 3, 1, 1'b1);
        run_op("idle_start", 3'd0, 32'h8765_4321, 5'd16, 32'h0000_8765, 16, 4, 1, 1'b0);

        // Abort a SHR by 20 partway through.
        @(negedge clock);
        mode = 3'd0; B = 32'hFFFF_0000; shifts = 5'd20; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        @(negedge clock);
        @(negedge clock);
        clear = 1'b1;
        @(negedge clock);
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("clear busy[%0d]", i), 32'(busy_w[i]), 32'd0);
            check($sformatf("clear done[%0d]", i), 32'(done_w[i]), 32'd0);
            check($sformatf("clear result[%0d]", i), res_w[i], 32'h0);
        end
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clock);
            if (done_w[0] || done_w[1]) saw_done = 1'b1;
        end
        check("aborted op no done", 32'(saw_done), 32'd0);

        run_op("ror_after_clear", 3'd3, 32'h0000_0001, 5'd1, 32'h8000_0000, 1, 1, 1, 1'b0);

        repeat (2) @(negedge clock);
        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
